mul_add_arbiter: RTL

//  Shares one non-stallable multiply-add pipeline (out = x*y + z, fixed latency LAT) between N_REQ requesters.

---
 rtl/mul_add_arb_pkg.sv | 24 ++
 rtl/mul_add_rsp_fifo.sv | 62 ++++++
 rtl/mul_add_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mul_add_arb_pkg.sv
// Shared types and helpers for the multiply-add pipeline arbiter.
// The typedefs describe the default configuration (4 requesters, 32-bit data).
package mul_add_arb_pkg;

    localparam int N_REQ_DFLT = 4;
    localparam int W_DFLT     = 32;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ID_W = id_w(N_REQ_DFLT);

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } mul_add_tag_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [W_DFLT-1:0] data;
    } mul_add_rsp_t;

endpackage

// File: rtl/mul_add_rsp_fifo.sv
// Synchronous response FIFO with occupancy count; entry type is a parameter.
// Pops on an empty FIFO are ignored; pushes into a full FIFO must never happen.
module mul_add_rsp_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0],
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  T                 push_data,
    input  logic             pop,
    output T                 pop_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T                  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              pop_ok;
    logic              full;

    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
        return (p == ADDR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty  = (count == '0);
    assign full   = (count == CNT_W'(DEPTH));
    assign pop_ok = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop_ok)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];

    // Upstream credit gating guarantees a free slot for every push.
    push_not_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/mul_add_arbiter.sv
// Round-robin, credit-gated front end sharing one fixed-latency multiply-add pipeline.
// Define MUL_ADD_ARB_STATS_EN to add the stat_issued / stat_blocked counters.
module mul_add_arbiter
    import mul_add_arb_pkg::*;
#(
    parameter int  N_REQ     = 4,
    parameter int  W         = 32,
    parameter int  LAT       = 3,
    parameter int  RSP_DEPTH = 4,
    localparam int IDW       = id_w(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_x,
    input  logic [N_REQ*W-1:0] req_y,
    input  logic [N_REQ*W-1:0] req_z,
    output logic [N_REQ-1:0]   req_ready,
    output logic [W-1:0]       pipe_x,
    output logic [W-1:0]       pipe_y,
    output logic [W-1:0]       pipe_z,
    input  logic [W-1:0]       pipe_out,
    output logic               rsp_valid,
    output logic [IDW-1:0]     rsp_id,
    output logic [W-1:0]       rsp_data,
`ifdef MUL_ADD_ARB_STATS_EN
    output logic [31:0]        stat_issued,
    output logic [31:0]        stat_blocked,
`endif
    input  logic               rsp_ready
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int OCC_W = $clog2(RSP_DEPTH + LAT + 1);

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
    } tag_t;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [W-1:0]   data;
    } rsp_t;

    tag_t             tag_p [LAT];
    logic [IDW-1:0]   rr_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic [OCC_W-1:0] inflight;
    logic [OCC_W-1:0] occ;
    logic             credit_ok;
    logic             issue_ok;
    logic             found;
    int               arb_idx;
    logic [IDW-1:0]   grant_id;
    logic             accept;
    logic             fifo_empty;
    rsp_t             push_entry;
    rsp_t             rsp_head;

    // Every accepted op owns one credit until its response is popped.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++)
            inflight = inflight + OCC_W'(tag_p[i].vld);
    end

    assign occ       = OCC_W'(fifo_count) + inflight;
    assign credit_ok = (occ < OCC_W'(RSP_DEPTH));
    assign issue_ok  = rst_n && credit_ok;

    // Scan from the far end back towards rr_ptr so the closest valid requester wins.
    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        arb_idx  = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            arb_idx = int'(rr_ptr) + k;
            if (arb_idx >= N_REQ)
                arb_idx = arb_idx - N_REQ;
            if (req_valid[arb_idx]) begin
                found    = 1'b1;
                grant_id = IDW'(arb_idx);
            end
        end
    end

    assign accept    = found && issue_ok;
    assign req_ready = accept ? (N_REQ'(1) << grant_id) : '0;
    assign pipe_x    = accept ? req_x[grant_id*W +: W] : '0;
    assign pipe_y    = accept ? req_y[grant_id*W +: W] : '0;
    assign pipe_z    = accept ? req_z[grant_id*W +: W] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_ptr <= '0;
        else if (accept)
            rr_ptr <= (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
    end

    // Tag stage k tracks the op whose operands were sampled k+1 edges ago.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++)
                tag_p[i] <= '0;
        end else begin
            tag_p[0] <= '{vld: accept, id: grant_id};
            for (int i = 1; i < LAT; i++)
                tag_p[i] <= tag_p[i-1];
        end
    end

    // Last tag stage lines up with pipe_out; capture both into the FIFO.
    assign push_entry = '{id: tag_p[LAT-1].id, data: pipe_out};

    mul_add_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .T     (rsp_t)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tag_p[LAT-1].vld),
        .push_data (push_entry),
        .pop       (rsp_ready),
        .pop_data  (rsp_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign rsp_valid = !fifo_empty;
    assign rsp_id    = rsp_head.id;
    assign rsp_data  = rsp_head.data;

`ifdef MUL_ADD_ARB_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued  <= '0;
            stat_blocked <= '0;
        end else begin
            if (accept)
                stat_issued <= sat_inc(stat_issued);
            if (|req_valid && !credit_ok)
                stat_blocked <= sat_inc(stat_blocked);
        end
    end
`endif

endmodule
